// File: rtl/ucsbece154b_icache_pkg.sv
// ucsbece154b_icache_pkg: FSM states, default geometry and derived address field widths.
package ucsbece154b_icache_pkg;

    typedef enum logic [1:0] {IDLE, MISS_REQ, FILL, RESPOND} state_t;

    localparam int DEF_SETS  = 8;
    localparam int DEF_WAYS  = 2;
    localparam int DEF_WORDS = 4;

    localparam int OFFSET_W = $clog2(DEF_WORDS);
    localparam int INDEX_W  = $clog2(DEF_SETS);
    localparam int TAG_W    = 30 - OFFSET_W - INDEX_W;

    function automatic int tag_w(input int sets, input int words);
        return 30 - $clog2(sets) - $clog2(words);
    endfunction

endpackage

// File: rtl/ucsbece154b_icache_way.sv
// ucsbece154b_icache_way: one way's tag, valid and data arrays with tag compare.
module ucsbece154b_icache_way import ucsbece154b_icache_pkg::*; #(
    parameter int NUM_SETS    = DEF_SETS,
    parameter int BLOCK_WORDS = DEF_WORDS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      flush_i,
    input  logic [$clog2(NUM_SETS)-1:0]               rd_idx_i,
    input  logic [$clog2(BLOCK_WORDS)-1:0]            rd_off_i,
    input  logic [tag_w(NUM_SETS, BLOCK_WORDS)-1:0]   rd_tag_i,
    output logic                                      valid_o,
    output logic                                      hit_o,
    output logic [31:0]                               rd_data_o,
    input  logic                                      wr_en_i,
    input  logic                                      wr_last_i,
    input  logic                                      wr_valid_i,
    input  logic [$clog2(NUM_SETS)-1:0]               wr_idx_i,
    input  logic [$clog2(BLOCK_WORDS)-1:0]            wr_off_i,
    input  logic [tag_w(NUM_SETS, BLOCK_WORDS)-1:0]   wr_tag_i,
    input  logic [31:0]                               wr_data_i
);
    localparam int TW = tag_w(NUM_SETS, BLOCK_WORDS);

    logic [TW-1:0]       tag_q  [NUM_SETS];
    logic [31:0]         data_q [NUM_SETS*BLOCK_WORDS];
    logic [NUM_SETS-1:0] valid_q;

    assign valid_o   = valid_q[rd_idx_i];
    assign hit_o     = valid_o && tag_q[rd_idx_i] == rd_tag_i;
    assign rd_data_o = data_q[{rd_idx_i, rd_off_i}];

    // Flush wins over a completing fill so a flushed line never becomes valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valid_q <= '0;
        else if (flush_i)
            valid_q <= '0;
        else if (wr_en_i && wr_last_i && wr_valid_i)
            valid_q[wr_idx_i] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en_i)
            data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
        if (wr_en_i && wr_last_i)
            tag_q[wr_idx_i] <= wr_tag_i;
    end

endmodule

// File: rtl/ucsbece154b_icache_nway.sv
// ucsbece154b_icache_nway: N-way set-associative instruction cache with round-robin replacement.
// Define ICACHE_PERF_EN to add saturating hit_counter/miss_counter ports.
module ucsbece154b_icache_nway import ucsbece154b_icache_pkg::*; #(
    parameter int NUM_SETS    = DEF_SETS,
    parameter int NUM_WAYS    = DEF_WAYS,
    parameter int BLOCK_WORDS = DEF_WORDS
) (
`ifdef ICACHE_PERF_EN
    output logic [31:0] hit_counter,
    output logic [31:0] miss_counter,
`endif
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    input  logic        Flush,
    output logic        Ready,
    output logic [31:0] Instruction,
    output logic        Busy,
    output logic [31:0] MemReadAddress,
    output logic        MemReadRequest,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);
    localparam int OW = $clog2(BLOCK_WORDS);
    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = tag_w(NUM_SETS, BLOCK_WORDS);
    localparam int WW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d, instr_q, instr_d, hit_data;
    logic [OW-1:0]       cnt_q, cnt_d, rd_off, req_off;
    logic [IW-1:0]       rd_idx, wr_idx;
    logic [WW-1:0]       way_q, way_d, victim;
    logic [WW-1:0]       rr_q [NUM_SETS];
    logic                hit_q, hit_d, flushed_q, flushed_d, hit, fill_we, fill_last;
    logic [NUM_WAYS-1:0] way_hit, way_valid;
    logic [31:0]         way_data [NUM_WAYS];
    logic                unused_bits;

    assign rd_idx      = ReadAddress[2+OW +: IW];
    assign rd_off      = ReadAddress[2 +: OW];
    assign wr_idx      = addr_q[2+OW +: IW];
    assign req_off     = addr_q[2 +: OW];
    assign fill_we     = state_q == FILL && MemDataReady;
    assign fill_last   = fill_we && cnt_q == OW'(BLOCK_WORDS - 1);
    assign unused_bits = ^{ReadAddress[1:0], addr_q[1:0]};

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        ucsbece154b_icache_way #(.NUM_SETS(NUM_SETS), .BLOCK_WORDS(BLOCK_WORDS)) u_way (
            .clk       (clk),
            .reset     (reset),
            .flush_i   (Flush),
            .rd_idx_i  (rd_idx),
            .rd_off_i  (rd_off),
            .rd_tag_i  (ReadAddress[31 -: TW]),
            .valid_o   (way_valid[w]),
            .hit_o     (way_hit[w]),
            .rd_data_o (way_data[w]),
            .wr_en_i   (fill_we && way_q == WW'(w)),
            .wr_last_i (fill_last),
            .wr_valid_i(!flushed_q),
            .wr_idx_i  (wr_idx),
            .wr_off_i  (cnt_q),
            .wr_tag_i  (addr_q[31 -: TW]),
            .wr_data_i (MemDataIn)
        );
    end

    // Descending scan leaves the lowest invalid way as victim, else the set's pointer.
    always_comb begin
        hit_data = '0;
        victim   = rr_q[rd_idx];
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            hit_data = hit_data | (way_hit[i] ? way_data[i] : 32'd0);
            victim   = way_valid[i] ? victim : WW'(i);
        end
    end

    assign hit = |way_hit;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        way_d     = way_q;
        instr_d   = instr_q;
        hit_d     = 1'b0;
        flushed_d = flushed_q || Flush;
        case (state_q)
            IDLE: begin
                hit_d   = ReadEnable && hit;
                instr_d = ReadEnable && hit ? hit_data : instr_q;
                if (ReadEnable && !hit) begin
                    state_d   = MISS_REQ;
                    addr_d    = ReadAddress;
                    way_d     = victim;
                    flushed_d = 1'b0;
                end
            end
            MISS_REQ: begin
                state_d = FILL;
                cnt_d   = '0;
            end
            FILL: begin
                cnt_d   = fill_we ? cnt_q + OW'(1) : cnt_q;
                instr_d = fill_we && cnt_q == req_off ? MemDataIn : instr_q;
                state_d = fill_last ? RESPOND : FILL;
            end
            RESPOND: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            instr_q   <= '0;
            cnt_q     <= '0;
            way_q     <= '0;
            hit_q     <= 1'b0;
            flushed_q <= 1'b0;
            for (int i = 0; i < NUM_SETS; i++)
                rr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            way_q     <= way_d;
            hit_q     <= hit_d;
            flushed_q <= flushed_d;
            if (fill_last)
                rr_q[wr_idx] <= rr_q[wr_idx] == WW'(NUM_WAYS - 1) ? '0 : rr_q[wr_idx] + WW'(1);
        end
    end

    assign Ready          = hit_q || state_q == RESPOND;
    assign Instruction    = instr_q;
    assign Busy           = state_q != IDLE;
    assign MemReadRequest = state_q == MISS_REQ;
    assign MemReadAddress = {addr_q[31:2+OW], {(OW+2){1'b0}}};

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        lookup;

    assign lookup = state_q == IDLE && ReadEnable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup && hit && !(&hit_cnt_q))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (lookup && !hit && !(&miss_cnt_q))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_counter  = hit_cnt_q;
    assign miss_counter = miss_cnt_q;
`endif

endmodule

// File: doc/ucsbece154b_icache_nway.md
UCSBECE154B_ICACHE_NWAY -- requirements
Module: ucsbece154b_icache_nway

Interface
REQ-001 Parameter NUM_SETS, default 8: number of sets; power of two, at least 2.
REQ-002 Parameter NUM_WAYS, default 2: associativity, 1 to 4.
REQ-003 Parameter BLOCK_WORDS, default 4: 32-bit words per line; power of two, at least 2.
REQ-004 Port clk, input, 1: the single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port ReadEnable, input, 1: fetch request, sampled only while Busy=0.
REQ-007 Port ReadAddress, input, 32: byte fetch address; bits [1:0] ignored.
REQ-008 Port Flush, input, 1: invalidate all lines.
REQ-009 Port Ready, output, 1: Instruction valid this cycle.
REQ-010 Port Instruction, output, 32: fetched word.
REQ-011 Port Busy, output, 1: cache cannot accept a request.
REQ-012 Port MemReadAddress, output, 32: block-aligned refill address.
REQ-013 Port MemReadRequest, output, 1: one-cycle refill start pulse.
REQ-014 Port MemDataIn, input, 32: refill word.
REQ-015 Port MemDataReady, input, 1: MemDataIn valid; words arrive in ascending order, one per assertion.
REQ-016 Ports hit_counter and miss_counter, output, 32 each: present only with ICACHE_PERF_EN.

Function
REQ-017 Address split SHALL be: offset = log2(BLOCK_WORDS) bits above bit 1, index = log2(NUM_SETS) bits above offset, tag = remaining upper bits.
REQ-018 FSM states SHALL be IDLE, MISS_REQ, FILL and RESPOND; reset state is IDLE.
REQ-019 IDLE + ReadEnable + hit: Ready=1 with the stored word on the next cycle; state remains IDLE; Busy stays 0.
REQ-020 IDLE + ReadEnable + miss: go to MISS_REQ and latch the address; Busy=1 from the next cycle until the RESPOND cycle inclusive.
REQ-021 MISS_REQ: MemReadRequest=1 for exactly one cycle with MemReadAddress = latched address with its offset and byte bits cleared; then go to FILL.
REQ-022 FILL: each MemDataReady writes MemDataIn to the victim way at a word counter that starts at 0; after word BLOCK_WORDS-1, write the tag, set valid, go to RESPOND.
REQ-023 RESPOND: Ready=1 with the requested word, Busy=1; return to IDLE next cycle. Miss latency = BLOCK_WORDS + 2 cycles plus memory wait.
REQ-024 Victim selection: the lowest-numbered invalid way; otherwise the per-set round-robin pointer, which increments modulo NUM_WAYS on each refill of that set.
REQ-025 Flush: clears all valid bits in one cycle from any state; round-robin pointers are unchanged.
REQ-026 Flush during MISS_REQ or FILL: the fill completes and returns the word, but the line is left invalid.
REQ-027 Flush together with a hit in IDLE: the hit data is returned, then the lines are invalidated.
REQ-028 Ready, MemReadRequest and Busy SHALL be 0 in every state/condition not listed above.
REQ-029 MemDataReady outside FILL SHALL be ignored.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, clear all valid bits, round-robin pointers and the word counter, and drive Ready, Busy, MemReadRequest and Instruction to 0.
REQ-031 Reset asserted mid-FILL SHALL abandon the fill; the partial line SHALL remain invalid.
REQ-032 Data and tag arrays need not be reset.

Configuration
REQ-033 With ICACHE_PERF_EN defined: hit_counter increments on each IDLE hit and miss_counter on each IDLE miss; both saturate at 32'hFFFFFFFF; both reset to 0; Flush does not clear them.
REQ-034 With ICACHE_PERF_EN undefined: no counter logic and no counter ports; all other behaviour is identical.

Structure
REQ-035 Shared package ucsbece154b_icache_pkg SHALL hold the FSM state enum and the derived widths: OFFSET_W, INDEX_W, TAG_W.
REQ-036 Sub-module ucsbece154b_icache_way SHALL hold one way's tag, valid and data arrays and its compare; it is instantiated NUM_WAYS times.

Verification
REQ-037 Cold fetch of 0x00000010 with defaults: MemReadRequest with MemReadAddress=0x00000010; feed words 0xA0..0xA3; Ready with Instruction=0xA0; miss_counter=1.
REQ-038 Then fetch 0x00000014: Ready next cycle with Instruction=0xA1, no MemReadRequest, hit_counter=1.
REQ-039 Fill 0x000, 0x080 and 0x100 (all set 0, 2 ways): the third refill evicts way 0; refetching 0x000 then misses.
REQ-040 Flush asserted during FILL: the requested word is still returned; refetching the same address misses.
REQ-041 reset=0 for 1 cycle mid-FILL: Busy=0 immediately; the next fetch of that address misses.
REQ-042 Drive 2^32 hits with counters preloaded by force to 32'hFFFFFFFE: hit_counter stays at 32'hFFFFFFFF.
